systolic_seq_ctrl: RTL and testbench

Sequencer for one N x M systolic-array tile multiply with inner dimension K.
- Accepts a start/done job handshake.
- Clears the PE accumulators.
- Drives skewed per-row A and per-column B feed enables.
- Holds the array enabled while partial sums drain, then pulses done.
- Sits between the tile scheduler and the array/operand-buffer datapath. Replaces the free-running load/momentum test controller.

---
 rtl/systolic_seq_ctrl_pkg.sv | 21 ++
 rtl/systolic_seq_ctrl_if.sv | 40 ++++
 rtl/systolic_seq_ctrl_skew.sv | 21 ++
 rtl/systolic_seq_ctrl.sv | 104 ++++++++++
 tb/tb_systolic_seq_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and derived-length helpers for the systolic tile sequencer.
// Optional build macro: SEQ_PERF_CNT_EN (stall performance counter).
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    function automatic int seq_last(input int n, input int m, input int k);
        return k + n + m - 2;
    endfunction

    function automatic int feed_len(input int n, input int m, input int k);
        return k + ((n > m) ? n : m) - 1;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Job handshake and array-control bundle between scheduler and sequencer.
// Optional build macro: SEQ_PERF_CNT_EN adds stall_cnt.
interface systolic_seq_ctrl_if #(
    parameter int N = 2,
    parameter int M = 2,
    parameter int K = 4
);
    localparam int CNT_W = $clog2(K + N + M);

    logic             start;
    logic             abort;
    logic             stall;
    logic             busy;
    logic             acc_clr;
    logic             array_en;
    logic [N-1:0]     a_en;
    logic [M-1:0]     b_en;
    logic [CNT_W-1:0] t_idx;
    logic             done;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    modport master (
        output start, abort, stall,
        input  busy, acc_clr, array_en, a_en, b_en, t_idx, done
`ifdef SEQ_PERF_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  start, abort, stall,
        output busy, acc_clr, array_en, a_en, b_en, t_idx, done
`ifdef SEQ_PERF_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/systolic_seq_ctrl_skew.sv
// Skewed lane window: lane l is enabled while l <= t < l+K.
// Optional build macro: SEQ_PERF_CNT_EN (not used here).
module skew_window_gen #(
    parameter int LANES = 2,
    parameter int K     = 4,
    parameter int CNT_W = 3
) (
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_t,
    output logic [LANES-1:0] o_lane
);
    localparam logic [CNT_W-1:0] K_T = CNT_W'(K);

    // t-l wraps to a value >= K when t < l, so one compare covers both bounds
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CNT_W-1:0] w_rel;
        assign w_rel     = i_t - CNT_W'(l);
        assign o_lane[l] = i_en && (w_rel < K_T);
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one N x M systolic tile multiply with inner dimension K.
// Optional build macro: SEQ_PERF_CNT_EN adds a saturating stall counter.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 2,
    parameter int K = 4
) (
    input logic clk,
    input logic rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(K + N + M);
    localparam int LAST  = seq_last(N, M, K);
    localparam int FLEN  = feed_len(N, M, K);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_CLEAR = ST_CLEAR;
    localparam logic [2:0] S_FEED  = ST_FEED;
    localparam logic [2:0] S_DRAIN = ST_DRAIN;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam logic [CNT_W-1:0] FEED_END = CNT_W'(FLEN - 1);
    localparam logic [CNT_W-1:0] LAST_T   = CNT_W'(LAST);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_t;
    logic             w_feed;
    logic             w_act;
    logic             w_run;

    assign w_feed = (r_state == S_FEED);
    assign w_act  = w_feed || (r_state == S_DRAIN);
    assign w_run  = w_act && !bus.stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_t     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_t     <= '0;
                    r_state <= bus.abort ? S_IDLE : S_FEED;
                end
                S_FEED, S_DRAIN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_t     <= '0;
                    end else if (!bus.stall) begin
                        r_t <= r_t + 1'b1;
                        if (w_feed && r_t == FEED_END)
                            r_state <= S_DRAIN;
                        else if (!w_feed && r_t == LAST_T)
                            r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    skew_window_gen #(.LANES(N), .K(K), .CNT_W(CNT_W)) u_a_win (
        .i_en   (w_feed && !bus.stall),
        .i_t    (r_t),
        .o_lane (bus.a_en)
    );

    skew_window_gen #(.LANES(M), .K(K), .CNT_W(CNT_W)) u_b_win (
        .i_en   (w_feed && !bus.stall),
        .i_t    (r_t),
        .o_lane (bus.b_en)
    );

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.acc_clr  = (r_state == S_CLEAR);
    assign bus.array_en = w_run;
    assign bus.done     = (r_state == S_DONE);
    assign bus.t_idx    = r_t;

`ifdef SEQ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    // an aborting cycle is not counted as a stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_stall_cnt <= '0;
        end else if (w_act && bus.stall && !bus.abort
                     && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench: two tile shapes driven in lockstep against a job model.
// Optional build macro: SEQ_PERF_CNT_EN also checks stall_cnt.
module tb_systolic_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.N(2), .M(2), .K(4)) if0 ();
    systolic_seq_ctrl_if #(.N(3), .M(2), .K(2)) if1 ();

    systolic_seq_ctrl #(.N(2), .M(2), .K(4)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    systolic_seq_ctrl #(.N(3), .M(2), .K(2)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    typedef logic [47:0] vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t q0[$];
    vec_t q1[$];

    int pn[2] = '{2, 3};
    int pm[2] = '{2, 2};
    int pk[2] = '{4, 2};

    // job progress: -1 idle, 0 clear, 1+t while sequencing, LAST+2 done
    int pos[2] = '{-1, -1};
    int tv[2]  = '{0, 0};
    int cnt[2] = '{0, 0};

    function automatic vec_t model_out(int d, bit rs, bit sl);
        int         last;
        int         tt;
        bit         act;
        logic [7:0] a;
        logic [7:0] b;
        logic [15:0] c;
        last = pk[d] + pn[d] + pm[d] - 2;
        a = '0;
        b = '0;
        if (!rs) return '0;
        act = (pos[d] >= 1) && (pos[d] <= last + 1);
        tt  = pos[d] - 1;
        for (int i = 0; i < pn[d]; i++)
            if (act && !sl && tt >= i && tt < i + pk[d]) a[i] = 1'b1;
        for (int j = 0; j < pm[d]; j++)
            if (act && !sl && tt >= j && tt < j + pk[d]) b[j] = 1'b1;
`ifdef SEQ_PERF_CNT_EN
        c = 16'(cnt[d]);
`else
        c = '0;
`endif
        return {c, 4'b0, pos[d] >= 0, pos[d] == 0, act && !sl,
                pos[d] == last + 2, a, b, 8'(tv[d])};
    endfunction

    task automatic model_step(int d, bit rs, bit st, bit ab, bit sl);
        int last;
        last = pk[d] + pn[d] + pm[d] - 2;
        if (!rs) begin
            pos[d] = -1;
            tv[d]  = 0;
            cnt[d] = 0;
        end else if (pos[d] == -1) begin
            if (st) pos[d] = 0;
        end else if (pos[d] == 0) begin
            cnt[d] = 0;
            tv[d]  = 0;
            pos[d] = ab ? -1 : 1;
        end else if (pos[d] <= last + 1) begin
            if (sl && !ab && cnt[d] < 65535) cnt[d]++;
            if (ab) begin
                pos[d] = -1;
                tv[d]  = 0;
            end else if (!sl) begin
                pos[d]++;
                tv[d]++;
            end
        end else begin
            pos[d] = -1;
        end
    endtask

    function automatic vec_t got0();
        logic [15:0] c;
`ifdef SEQ_PERF_CNT_EN
        c = if0.stall_cnt;
`else
        c = '0;
`endif
        return {c, 4'b0, if0.busy, if0.acc_clr, if0.array_en, if0.done,
                8'(if0.a_en), 8'(if0.b_en), 8'(if0.t_idx)};
    endfunction

    function automatic vec_t got1();
        logic [15:0] c;
`ifdef SEQ_PERF_CNT_EN
        c = if1.stall_cnt;
`else
        c = '0;
`endif
        return {c, 4'b0, if1.busy, if1.acc_clr, if1.array_en, if1.done,
                8'(if1.a_en), 8'(if1.b_en), 8'(if1.t_idx)};
    endfunction

    task automatic cyc(bit rs, bit st, bit ab, bit sl);
        @(posedge clk);
        #1;
        rst = rs;
        if0.start = st;
        if0.abort = ab;
        if0.stall = sl;
        if1.start = st;
        if1.abort = ab;
        if1.stall = sl;
        q0.push_back(model_out(0, rs, sl));
        q1.push_back(model_out(1, rs, sl));
        model_step(0, rs, st, ab, sl);
        model_step(1, rs, st, ab, sl);
    endtask

    initial begin : monitor
        vec_t e;
        vec_t g;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                g = got0();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL dut0_out @%0t got %h expected %h",
                             $time, g, e);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                g = got1();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL dut1_out @%0t got %h expected %h",
                             $time, g, e);
                end
            end
        end
    end

    initial begin : stim
        if0.start = 1'b0;
        if0.abort = 1'b0;
        if0.stall = 1'b0;
        if1.start = 1'b0;
        if1.abort = 1'b0;
        if1.stall = 1'b0;

        repeat (3) cyc(0, 0, 0, 0);

        // nominal job
        cyc(1, 1, 0, 0);
        repeat (12) cyc(1, 0, 0, 0);

        // stall for three cycles at t=2
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 1);
        repeat (14) cyc(1, 0, 0, 0);

        // abort while draining, then a fresh job
        cyc(1, 1, 0, 0);
        repeat (6) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (12) cyc(1, 0, 0, 0);

        // start and abort together in idle: job still runs
        cyc(1, 1, 1, 0);
        repeat (12) cyc(1, 0, 0, 0);

        // asynchronous reset between edges during feed
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        #1;
        checks++;
        if (got0() !== '0) begin
            errors++;
            $display("FAIL async_rst0 got %h expected 0", got0());
        end
        checks++;
        if (got1() !== '0) begin
            errors++;
            $display("FAIL async_rst1 got %h expected 0", got1());
        end
        repeat (5) cyc(1, 0, 0, 0);

        // start held high: back-to-back jobs
        repeat (40) cyc(1, 1, 0, 0);
        repeat (4) cyc(1, 0, 0, 0);

        repeat (1500)
            cyc($urandom_range(199) != 0,
                $urandom_range(3) == 0,
                $urandom_range(29) == 0,
                $urandom_range(3) == 0);

        repeat (3) cyc(1, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
